// File: rtl/turbo_enc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | turbo_enc_pkg                                                          |
// | Shared constants, generator taps and FSM encoding for the LTE RSC enc. |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
package turbo_enc_pkg;

  localparam int KLEN_W   = 13;
  localparam int K_MIN    = 40;
  localparam int K_MAX    = 6144;
  localparam int TAIL_LEN = 3;

  // Tap masks: bit 3 is the current input, bits 2..0 weight D, D^2, D^3.
  localparam logic [3:0] G0 = 4'b1011;
  localparam logic [3:0] G1 = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_state_e;

endpackage
`default_nettype wire

// File: rtl/turbo_rsc_encoder_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | turbo_rsc_encoder_if                                                   |
// | Control, input-stream and output-pair signals of the RSC encoder.      |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
interface turbo_rsc_encoder_if #(
  parameter int KLEN_W = turbo_enc_pkg::KLEN_W
);
  logic              start;
  logic [KLEN_W-1:0] blk_len;
  logic              in_valid;
  logic              in_ready;
  logic              in_bit;
  logic              out_valid;
  logic              out_ready;
  logic              out_sys;
  logic              out_par;
  logic              out_tail;
  logic              out_last;
  logic              busy;
  logic              len_err;

  modport slave (
    input  start, blk_len, in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_sys, out_par, out_tail, out_last, busy, len_err
  );

  modport master (
    output start, blk_len, in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_sys, out_par, out_tail, out_last, busy, len_err
  );
endinterface
`default_nettype wire

// File: rtl/rsc_trellis_step.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rsc_trellis_step                                                       |
// | One combinational step of the 8-state RSC trellis (data or tail mode). |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module rsc_trellis_step
  import turbo_enc_pkg::*;
(
  input  logic i_d1,
  input  logic i_d2,
  input  logic i_d3,
  input  logic i_bit,
  input  logic i_tail_mode,
  output logic o_d1,
  output logic o_d2,
  output logic o_d3,
  output logic o_sys,
  output logic o_par
);

  logic [2:0] w_reg;
  logic       w_fb;
  logic       w_a;

  assign w_reg = {i_d1, i_d2, i_d3};
  assign w_fb  = ^(G0[2:0] & w_reg);

  // Tail mode feeds back the register so the recursion input becomes zero.
  assign w_a   = i_tail_mode ? 1'b0 : (i_bit ^ w_fb);
  assign o_sys = i_tail_mode ? w_fb : i_bit;
  assign o_par = w_a ^ (^(G1[2:0] & w_reg));

  assign o_d1 = w_a;
  assign o_d2 = i_d1;
  assign o_d3 = i_d2;

endmodule
`default_nettype wire

// File: rtl/turbo_rsc_encoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | turbo_rsc_encoder                                                      |
// | Serial LTE RSC constituent encoder; TURBO_ENC_TAIL_EN adds 3-beat tail.|
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module turbo_rsc_encoder #(
  parameter int KLEN_W = turbo_enc_pkg::KLEN_W,
  parameter int K_MIN  = turbo_enc_pkg::K_MIN,
  parameter int K_MAX  = turbo_enc_pkg::K_MAX
) (
  input  logic               clk,
  input  logic               rst_n,
  turbo_rsc_encoder_if.slave bus
);
  import turbo_enc_pkg::*;

  localparam logic [KLEN_W-1:0] c_k_min = KLEN_W'(K_MIN);
  localparam logic [KLEN_W-1:0] c_k_max = KLEN_W'(K_MAX);

  enc_state_e        r_state;
  enc_state_e        w_state_nxt;
  logic [2:0]        r_d;
  logic [KLEN_W-1:0] r_k;
  logic [KLEN_W-1:0] r_cnt;
  logic              r_out_valid;
  logic              r_out_sys;
  logic              r_out_par;
  logic              r_out_last;
  logic              r_len_err;

  logic w_slot_free, w_len_ok, w_start_ok, w_start_bad;
  logic w_accept, w_last_data, w_step, w_tail_mode;
  logic w_in_ready, w_busy;
  logic w_d1, w_d2, w_d3, w_sys, w_par;

  assign w_slot_free = !r_out_valid || bus.out_ready;
  assign w_len_ok    = (bus.blk_len >= c_k_min) && (bus.blk_len <= c_k_max);
  assign w_start_ok  = (r_state == IDLE) && bus.start && w_len_ok;
  assign w_start_bad = (r_state == IDLE) && bus.start && !w_len_ok;
  assign w_accept    = (r_state == DATA) && w_slot_free && bus.in_valid;
  assign w_last_data = (r_cnt == (r_k - KLEN_W'(1)));

`ifdef TURBO_ENC_TAIL_EN
  logic [1:0] r_tcnt;
  logic       r_out_tail;
  logic       w_tail_fire;
  logic       w_last_tail;

  assign w_tail_fire = (r_state == TAIL) && w_slot_free;
  assign w_last_tail = (r_tcnt == 2'(TAIL_LEN - 1));
  assign w_tail_mode = (r_state == TAIL);
  assign w_step      = w_accept || w_tail_fire;
  assign bus.out_tail = r_out_tail;
`else
  assign w_tail_mode  = 1'b0;
  assign w_step       = w_accept;
  assign bus.out_tail = 1'b0;
`endif

  rsc_trellis_step u_step (
    .i_d1        (r_d[2]),
    .i_d2        (r_d[1]),
    .i_d3        (r_d[0]),
    .i_bit       (bus.in_bit),
    .i_tail_mode (w_tail_mode),
    .o_d1        (w_d1),
    .o_d2        (w_d2),
    .o_d3        (w_d3),
    .o_sys       (w_sys),
    .o_par       (w_par)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_busy      = (r_state != IDLE);
    case (r_state)
      IDLE: if (w_start_ok) w_state_nxt = DATA;
      DATA: begin
        w_in_ready = w_slot_free;
`ifdef TURBO_ENC_TAIL_EN
        if (w_accept && w_last_data) w_state_nxt = TAIL;
`else
        if (w_accept && w_last_data) w_state_nxt = IDLE;
`endif
      end
`ifdef TURBO_ENC_TAIL_EN
      TAIL: if (w_tail_fire && w_last_tail) w_state_nxt = IDLE;
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d         <= 3'b000;
      r_k         <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_sys   <= 1'b0;
      r_out_par   <= 1'b0;
      r_out_last  <= 1'b0;
      r_len_err   <= 1'b0;
`ifdef TURBO_ENC_TAIL_EN
      r_tcnt      <= 2'd0;
      r_out_tail  <= 1'b0;
`endif
    end else begin
      r_len_err <= w_start_bad;
      if (w_start_ok) begin
        r_k   <= bus.blk_len;
        r_cnt <= '0;
        r_d   <= 3'b000;
`ifdef TURBO_ENC_TAIL_EN
        r_tcnt <= 2'd0;
`endif
      end
      if (w_accept) r_cnt <= r_cnt + KLEN_W'(1);
      // Loading a new pair takes precedence over draining the old one.
      if (w_step) begin
        r_d         <= {w_d1, w_d2, w_d3};
        r_out_valid <= 1'b1;
        r_out_sys   <= w_sys;
        r_out_par   <= w_par;
`ifdef TURBO_ENC_TAIL_EN
        r_out_tail  <= w_tail_mode;
        r_out_last  <= w_tail_fire && w_last_tail;
        if (w_tail_fire) r_tcnt <= r_tcnt + 2'd1;
`else
        r_out_last  <= w_last_data;
`endif
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sys   = r_out_sys;
  assign bus.out_par   = r_out_par;
  assign bus.out_last  = r_out_last;
  assign bus.len_err   = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_turbo_rsc_encoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_turbo_rsc_encoder                                                   |
// | Directed and randomized-stall bench for the RSC encoder.               |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module tb_turbo_rsc_encoder;
  import turbo_enc_pkg::*;

`ifdef TURBO_ENC_TAIL_EN
  localparam bit TAIL_ON = 1'b1;
`else
  localparam bit TAIL_ON = 1'b0;
`endif

  typedef struct {
    int   len;
    logic exp_err;
  } len_vec_t;

  typedef struct {
    logic [7:0] bits;
    logic [7:0] exp_par;
  } pat_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  turbo_rsc_encoder_if #(.KLEN_W(KLEN_W)) enc_if ();

  turbo_rsc_encoder #(
    .KLEN_W (KLEN_W),
    .K_MIN  (K_MIN),
    .K_MAX  (K_MAX)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (enc_if.slave)
  );

  int         n_pass = 0;
  int         n_checks = 0;
  logic       bits [0:K_MAX-1];
  logic [3:0] exp_v [0:K_MAX+2];
  int         n_exp;
  logic [7:0] obs_par8;
  len_vec_t   lv [6];
  pat_vec_t   pv [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] all_outs();
    return {enc_if.out_valid, enc_if.out_sys, enc_if.out_par, enc_if.out_tail,
            enc_if.out_last, enc_if.busy, enc_if.len_err, enc_if.in_ready};
  endfunction

  // Reference: a = u ^ s2 ^ s3, z = a ^ s1 ^ s3; tail drives a to zero.
  task automatic model_block(input int k);
    logic s1, s2, s3, a;
    s1 = 1'b0; s2 = 1'b0; s3 = 1'b0; n_exp = 0;
    for (int i = 0; i < k; i++) begin
      a = bits[i] ^ s2 ^ s3;
      exp_v[n_exp] = {bits[i], a ^ s1 ^ s3, 1'b0, (i == k - 1) && !TAIL_ON};
      s3 = s2; s2 = s1; s1 = a;
      n_exp++;
    end
    if (TAIL_ON) begin
      for (int t = 0; t < 3; t++) begin
        exp_v[n_exp] = {s2 ^ s3, s1 ^ s3, 1'b1, t == 2};
        s3 = s2; s2 = s1; s1 = 1'b0;
        n_exp++;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    enc_if.start = 1'b0;
    enc_if.in_valid = 1'b0;
    enc_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_block(input int k, input int stall_pct, input int gap_pct,
                           input int restart_at, input int abort_at);
    int idx, opos, cyc, budget;
    bit held, restarted, saw_err;
    logic [3:0] hold_v, got;
    idx = 0; opos = 0; cyc = 0; held = 0; restarted = 0; saw_err = 0;
    budget = 8 * k + 200;
    obs_par8 = '0;
    hold_v = '0;
    model_block(k);
    @(posedge clk); #1;
    enc_if.start = 1'b1;
    enc_if.blk_len = KLEN_W'(k);
    enc_if.in_valid = 1'b0;
    enc_if.out_ready = 1'b1;
    @(posedge clk); #1;
    enc_if.start = 1'b0;
    enc_if.in_valid = ($urandom_range(99) >= 32'(gap_pct));
    enc_if.in_bit = bits[0];
    enc_if.out_ready = ($urandom_range(99) >= 32'(stall_pct));
    while (opos < n_exp && cyc < budget) begin
      @(negedge clk);
      got = {enc_if.out_sys, enc_if.out_par, enc_if.out_tail, enc_if.out_last};
      if (enc_if.len_err) saw_err = 1'b1;
      if (held) chk("stall_hold", {27'd0, enc_if.out_valid, got}, {27'd0, 1'b1, hold_v});
      held = 1'b0;
      if (enc_if.out_valid && !enc_if.out_ready) begin
        chk("stall_in_ready", 32'(enc_if.in_ready), 32'd0);
        held = 1'b1;
        hold_v = got;
      end
      if (enc_if.out_valid && enc_if.out_ready) begin
        chk($sformatf("pair[%0d] k=%0d", opos, k), 32'(got), 32'(exp_v[opos]));
        if (opos < 8) obs_par8[opos] = enc_if.out_par;
        opos++;
      end
      if (enc_if.in_valid && enc_if.in_ready) idx++;
      if (abort_at >= 0 && idx >= abort_at) break;
      @(posedge clk); #1;
      enc_if.start = 1'b0;
      if (restart_at >= 0 && idx == restart_at && !restarted) begin
        enc_if.start = 1'b1;
        enc_if.blk_len = KLEN_W'(100);
        restarted = 1'b1;
      end
      enc_if.in_valid = (idx < k) && ($urandom_range(99) >= 32'(gap_pct));
      enc_if.in_bit = (idx < k) ? bits[idx] : 1'b0;
      enc_if.out_ready = ($urandom_range(99) >= 32'(stall_pct));
      cyc++;
    end
    if (abort_at < 0) begin
      chk($sformatf("pair_count k=%0d", k), 32'(opos), 32'(n_exp));
      chk("no_len_err", 32'(saw_err), 32'd0);
      chk("busy_end", 32'(enc_if.busy), 32'd0);
      @(posedge clk); #1;
      enc_if.in_valid = 1'b0;
      enc_if.out_ready = 1'b1;
      @(negedge clk);
      chk("valid_drop", 32'(enc_if.out_valid), 32'd0);
    end
  endtask

  initial begin
    lv[0] = '{len: 0,    exp_err: 1'b1};
    lv[1] = '{len: 39,   exp_err: 1'b1};
    lv[2] = '{len: 40,   exp_err: 1'b0};
    lv[3] = '{len: 6144, exp_err: 1'b0};
    lv[4] = '{len: 6145, exp_err: 1'b1};
    lv[5] = '{len: 8191, exp_err: 1'b1};
    // First eight parity bits, LSB = first pair, for the given 8-bit prefix.
    pv[0] = '{bits: 8'h00, exp_par: 8'h00};
    pv[1] = '{bits: 8'h01, exp_par: 8'h4F};
    pv[2] = '{bits: 8'h02, exp_par: 8'h9E};
    pv[3] = '{bits: 8'hFF, exp_par: 8'hC5};

    enc_if.start = 1'b0;
    enc_if.blk_len = '0;
    enc_if.in_valid = 1'b0;
    enc_if.in_bit = 1'b0;
    enc_if.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 32'(all_outs()), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    foreach (lv[i]) begin
      @(posedge clk); #1;
      enc_if.start = 1'b1;
      enc_if.blk_len = KLEN_W'(lv[i].len);
      @(posedge clk); #1;
      enc_if.start = 1'b0;
      @(negedge clk);
      chk($sformatf("len_err len=%0d", lv[i].len), 32'(enc_if.len_err), 32'(lv[i].exp_err));
      chk($sformatf("busy len=%0d", lv[i].len), 32'(enc_if.busy), 32'(!lv[i].exp_err));
      chk($sformatf("in_ready len=%0d", lv[i].len), 32'(enc_if.in_ready), 32'(!lv[i].exp_err));
      @(negedge clk);
      chk("len_err_pulse", 32'(enc_if.len_err), 32'd0);
      if (!lv[i].exp_err) do_reset();
    end

    foreach (pv[p]) begin
      for (int i = 0; i < 40; i++) bits[i] = (i < 8) ? pv[p].bits[i] : 1'b0;
      run_block(40, 0, 0, -1, -1);
      chk($sformatf("par8 pat=%02h", pv[p].bits), 32'(obs_par8), 32'(pv[p].exp_par));
    end

    // Impulse under stalls, with a stray start during DATA.
    for (int i = 0; i < 40; i++) bits[i] = (i == 0);
    run_block(40, 40, 30, 10, -1);
    chk("par8 stalled impulse", 32'(obs_par8), 32'h4F);

    for (int i = 0; i < K_MAX; i++) bits[i] = 1'($urandom_range(1));
    run_block(K_MAX, 30, 20, -1, -1);

    for (int i = 0; i < 512; i++) bits[i] = 1'($urandom_range(1));
    run_block(512, 0, 0, -1, 100);
    @(posedge clk); #1;
    rst_n = 1'b0;
    enc_if.in_valid = 1'b0;
    enc_if.out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_block_reset", 32'(all_outs()), 32'd0);

    for (int i = 0; i < 40; i++) bits[i] = (i == 0);
    run_block(40, 0, 0, -1, -1);
    chk("par8 after reset", 32'(obs_par8), 32'h4F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
